// File: rtl/dmem_pkg.sv
// Shared types and helpers for the line-granular data memory responder.
// Also used by the dcache flush logic for line-index extraction.
package dmem_pkg;

   localparam int LINE_W_DEF   = 256;
   localparam int DEPTH_DEF    = 512;
   localparam int OFFSET_W_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Line index of a byte address; depth must be a power of two.
   function automatic logic [31:0] line_index(
      input logic [31:0] addr,
      input int          offset_w,
      input int          depth
   );
      return (addr >> offset_w) & 32'(depth - 1);
   endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port synchronous line array with registered read data.
// The array is named memory so benches can preload and inspect it.
module dmem_line_array #(
   parameter int LINE_W = 256,
   parameter int DEPTH  = 512,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] memory [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         memory[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= memory[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the cache-to-memory line interface.
// One line read/write per handshake, ack after a fixed latency.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int LINE_W   = LINE_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = OFFSET_W_DEF,
   parameter int LATENCY  = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);

   localparam int IDX_W = $clog2(DEPTH);

   if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..255");
   end

   if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of two");
   end

   state_t            state_q;
   state_t            state_d;
   logic [7:0]        cnt_q;
   logic [7:0]        cnt_d;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  live_idx;
   logic [IDX_W-1:0]  mem_addr;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] mem_wdata;
   logic              wr_q;
   logic              mem_wr;
   logic              accept;
   logic              fire;
   logic              mem_we;
   logic              mem_re;
   logic              ack_q;

   assign live_idx =
      IDX_W'(line_index(32'(addr_i), OFFSET_W, DEPTH));

   // ack is a flop behind the ACK state, landing at E0+LATENCY
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= (state_q == ACK);
         if (accept) begin
            idx_q   <= live_idx;
            wdata_q <= data_i;
            wr_q    <= write_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i) begin
               cnt_d   = 8'(LATENCY - 1);
               state_d = (LATENCY == 1) ? ACK : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // With LATENCY=1 the access happens at acceptance, so use live fields
   always_comb begin
      accept    = (state_q == IDLE) && enable_i;
      fire      = (state_d == ACK) && (state_q != ACK);
      mem_addr  = accept ? live_idx : idx_q;
      mem_wdata = accept ? data_i   : wdata_q;
      mem_wr    = accept ? write_i  : wr_q;
      mem_we    = fire && mem_wr;
      mem_re    = fire && !mem_wr;
   end

   dmem_line_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk_i),
      .rst_n (rst_i),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (data_o)
   );

   assign ack_o = ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder at LATENCY 10 and 1.
// Memory contents are modelled as plain per-line arrays.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int LAT = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  addr;
   logic [31:0]  addr1;
   logic [255:0] data;
   logic [255:0] data1;
   logic [255:0] rdata;
   logic [255:0] rdata1;
   logic         enable;
   logic         enable1;
   logic         write;
   logic         write1;
   logic         ack;
   logic         ack1;

   int           tests = 0;
   int           fails = 0;
   logic [255:0] ref_mem [512];
   logic [255:0] ref1 [512];
   logic [255:0] exp_data;
   logic [255:0] old;
   logic [31:0]  seen [13];
   int           acks;
   int           late;

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(LAT)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .addr_i   (addr),
      .data_i   (data),
      .enable_i (enable),
      .write_i  (write),
      .ack_o    (ack),
      .data_o   (rdata)
   );

   dmem_responder #(.LATENCY(1)) dut1 (
      .clk_i    (clk),
      .rst_i    (rst),
      .addr_i   (addr1),
      .data_i   (data1),
      .enable_i (enable1),
      .write_i  (write1),
      .ack_o    (ack1),
      .data_o   (rdata1)
   );

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 32) % 512);
   endfunction

   task automatic check(
      input string        tag,
      input logic [255:0] obs,
      input logic [255:0] exp
   );
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic txn(
      input logic [31:0]  a,
      input logic [255:0] d,
      input logic         w,
      input bit           mangle,
      input string        tag
   );
      int           n;
      int           i;
      logic [255:0] prev;
      i    = idx_of(a);
      prev = ref_mem[i];
      @(negedge clk);
      addr   = a;
      data   = d;
      write  = w;
      enable = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (mangle && n == 3) begin
            addr   = a + 32'h20;
            data   = ~d;
            write  = ~w;
            enable = 1'b0;
         end
         if (w && n == LAT - 2)
            check({tag, "_pre"}, dut.u_array.memory[i], prev);
         if (ack) break;
      end
      enable = 1'b0;
      check({tag, "_lat"}, 256'(n), 256'(LAT));
      if (w) ref_mem[i] = d;
      else exp_data = ref_mem[i];
      check({tag, "_data"}, rdata, exp_data);
      if (w) check({tag, "_mem"}, dut.u_array.memory[i], d);
      @(posedge clk);
      #1;
      check({tag, "_ackoff"}, 256'(ack), 256'(0));
      check({tag, "_hold"}, rdata, exp_data);
   endtask

   initial begin
      rst     = 1'b0;
      addr    = '0;
      addr1   = '0;
      data    = '0;
      data1   = '0;
      enable  = 1'b0;
      enable1 = 1'b0;
      write   = 1'b0;
      write1  = 1'b0;
      for (int i = 0; i < 512; i++) begin
         ref_mem[i] = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
         ref1[i]    = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
      end
      ref_mem[0] = 256'h5;
      for (int i = 0; i < 512; i++) begin
         dut.u_array.memory[i]  <= ref_mem[i];
         dut1.u_array.memory[i] <= ref1[i];
      end
      #1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 256'(ack), 256'(0));
      check("rst_data", rdata, 256'(0));
      check("rst_state", 256'(dut.state_q), 256'(IDLE));
      check("rst_ack1", 256'(ack1), 256'(0));
      check("rst_data1", rdata1, 256'(0));
      @(negedge clk);
      rst      = 1'b1;
      exp_data = '0;
      repeat (2) @(posedge clk);

      txn(32'h0, 256'h0, 1'b0, 1'b0, "rd0");
      check("rd0_val", rdata, 256'h5);
      txn(32'h400, 256'hDEADBEEF, 1'b1, 1'b0, "wr400");
      check("wr400_idx32", dut.u_array.memory[32], 256'hDEADBEEF);
      txn(32'h400, 256'h0, 1'b0, 1'b0, "rd400");
      check("rd400_val", rdata, 256'hDEADBEEF);

      txn(32'h20, 256'hCAFEF00D, 1'b1, 1'b1, "mangle");
      check("mangle_idx1", dut.u_array.memory[1], 256'hCAFEF00D);
      check("mangle_untouched", dut.u_array.memory[2], ref_mem[2]);

      txn(32'h401F, 256'h1234, 1'b1, 1'b0, "wrap_wr");
      check("wrap_mem0", dut.u_array.memory[0], 256'h1234);
      txn(32'h801F, 256'h0, 1'b0, 1'b0, "wrap_rd");
      check("wrap_val", rdata, 256'h1234);

      old = ref_mem[3];
      @(negedge clk);
      addr   = 32'h60;
      data   = {8{32'hA5A5_5A5A}};
      write  = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rstbusy_ack", 256'(ack), 256'(0));
      check("rstbusy_data", rdata, 256'(0));
      check("rstbusy_mem3", dut.u_array.memory[3], old);
      @(negedge clk);
      rst      = 1'b1;
      exp_data = '0;
      @(posedge clk);
      #1;
      check("rstbusy_idle", 256'(dut.state_q), 256'(IDLE));
      late = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         late += int'(ack);
      end
      check("rstbusy_noack", 256'(late), 256'(0));
      check("rstbusy_mem3_after", dut.u_array.memory[3], old);

      for (int k = 0; k < 24; k++) begin
         logic [31:0]  a;
         logic [255:0] d;
         a = (32'($urandom_range(0, 7)) << 5)
           | 32'($urandom_range(0, 31))
           | (32'($urandom_range(0, 3)) << 14);
         d = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
         txn(a, d, 1'($urandom_range(0, 1)), 1'b0, "rand");
      end

      @(negedge clk);
      addr1   = $urandom & 32'h3FE0;
      write1  = 1'b0;
      enable1 = 1'b1;
      @(posedge clk);
      seen[0] = addr1;
      #1;
      acks = 0;
      for (int k = 1; k <= 12; k++) begin
         addr1 = $urandom;
         @(posedge clk);
         seen[k] = addr1;
         #1;
         acks += int'(ack1);
         check("l1_ack", 256'(ack1), 256'(k % 2 == 1));
         if (k % 2 == 1)
            check("l1_data", rdata1, ref1[idx_of(seen[k-1])]);
      end
      enable1 = 1'b0;
      check("l1_count", 256'(acks), 256'(6));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
